// File: rtl/moore_seq_detector.sv
// Serial Moore sequence detector with a run-time loadable N-bit pattern,
// selectable overlap, and a saturating match counter. All outputs are registers.
module moore_seq_detector #(
    parameter int             N       = 4,
    parameter int             CNT_W   = 4,
    parameter logic [N-1:0]   PAT_RST = 4'b1011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x1,
    input  logic             load,
    input  logic [N-1:0]     pat_in,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic [3:0]       state,
    output logic             z1,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    logic [N-1:0]     pat_q;
    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic             z1_q;
    logic [CNT_W-1:0] match_cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_sat_q;

    // pre_ok[s][k]: the k-1 bits preceding x1 in "pat[N-1:N-s],x1" equal the
    // first k-1 pattern bits, i.e. the KMP failure table minus the x1 term.
    logic [N:0] pre_ok [0:N];
    logic [N:0] x_ok;

    for (genvar gi = 0; gi <= N; gi++) begin : g_s
        assign pre_ok[gi][0] = 1'b0;
        for (genvar gk = 1; gk <= N; gk++) begin : g_k
            if (gk > gi + 1) begin : g_none
                assign pre_ok[gi][gk] = 1'b0;
            end else if (gk == 1) begin : g_one
                assign pre_ok[gi][gk] = 1'b1;
            end else begin : g_cmp
                assign pre_ok[gi][gk] =
                    (pat_q[N-1 -: gk-1] == pat_q[N-gi+gk-2 -: gk-1]);
            end
        end
    end

    assign x_ok[0] = 1'b0;
    for (genvar gk = 1; gk <= N; gk++) begin : g_x
        assign x_ok[gk] = (pat_q[N-gk] == x1);
    end

    logic [3:0] s_eff;
    logic [N:0] row;
    logic [N:0] hit;

    always_comb begin
        // Non-overlapping mode restarts from scratch after a full match.
        s_eff = (state_q == 4'(N) && !overlap) ? 4'd0 : state_q;
        row   = '0;
        for (int s = 0; s <= N; s++) begin
            if (s_eff == 4'(s)) begin
                row = pre_ok[s];
            end
        end
        hit     = row & x_ok;
        state_d = 4'd0;
        for (int k = 1; k <= N; k++) begin
            if (hit[k]) begin
                state_d = 4'(k);
            end
        end
        cnt_inc = match_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q       <= PAT_RST;
            state_q     <= 4'd0;
            z1_q        <= 1'b0;
            match_cnt_q <= '0;
            cnt_sat_q   <= 1'b0;
        end else begin
            if (load) begin
                pat_q   <= pat_in;
                state_q <= 4'd0;
                z1_q    <= 1'b0;
            end else if (en) begin
                state_q <= state_d;
                z1_q    <= (state_d == 4'(N));
            end

            // Clear beats a same-cycle increment; saturation freezes the count.
            if (clr_cnt) begin
                match_cnt_q <= '0;
                cnt_sat_q   <= 1'b0;
            end else if (en && !load && state_d == 4'(N) && !cnt_sat_q) begin
                match_cnt_q <= cnt_inc;
                cnt_sat_q   <= &cnt_inc;
            end
        end
    end

    assign state     = state_q;
    assign z1        = z1_q;
    assign match_cnt = match_cnt_q;
    assign cnt_sat   = cnt_sat_q;

endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised Moore-style serial sequence detector; successor to the fixed 3-bit-state Moore machine.
- Pattern length is a parameter, and the pattern itself is loadable at run time.
- Overlap and non-overlap detection are selectable, and a saturating match counter is added.
- Sits behind the Tiny Tapeout top wrapper:
  - x1 comes from ui_in[0].
  - state, z1 and count drive uo_out.

Parameters:
- N, 4, pattern length in bits; legal range 2..8.
- CNT_W, 4, match counter width; legal range 1..8.
- PAT_RST, 4'b1011, pattern register reset value, N bits wide; MSB is the first bit expected.

Ports:
- clk  input  1  global clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; x1 is consumed only on cycles where en=1.
- x1  input  1  serial data bit.
- load  input  1  pattern load strobe.
- pat_in  input  N  new pattern; bit N-1 is the first bit of the sequence.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clr_cnt  input  1  synchronous clear of match_cnt and cnt_sat.
- state  output  4  registered Moore state = number of pattern bits currently matched (0..N).
- z1  output  1  Moore output, equal to (state == N).
- match_cnt  output  CNT_W  number of detected matches, saturating.
- cnt_sat  output  1  high while match_cnt equals 2^CNT_W-1.

Behaviour:
- Reset (rst=1 at a clk edge): pattern register = PAT_RST, state = 0, z1 = 0, match_cnt = 0, cnt_sat = 0.
  - Reset overrides every other input, including when asserted mid-sequence.
- z1 and cnt_sat are pure functions of registers; there is no combinational path from any input to any output.
- State meaning: state = s means the last s consumed bits equal pat[N-1 : N-s].
- Next state when en=1 and load=0, from state s < N:
  - Form the string S = pat[N-1 : N-s] followed by x1 (length s+1).
  - next = the largest k in min(s+1, N) .. 1 such that pat[N-1 : N-k] equals the last k bits of S; 0 if no k matches.
- Next state from state N:
  - overlap=1: S = full pattern followed by x1, and k ranges over N..1 (k=N only if the pattern is periodic appropriately).
  - overlap=0: treated as s=0, so next = 1 if x1 == pat[N-1], else 0.
- en=0: state, match_cnt and cnt_sat hold; z1 holds with state.
- Detection latency: z1 rises on the clock edge that consumes the last pattern bit and is visible the cycle after. It stays high exactly as long as state == N.
- load=1 (priority over en):
  - Pattern register ← pat_in and state ← 0; x1 is ignored that cycle.
  - match_cnt is unchanged.
  - The new pattern is effective for the next consumed bit.
- Counter update: on an edge where en=1, load=0 and next state == N, match_cnt increments by 1.
  - At 2^CNT_W-1 it holds (saturates) and cnt_sat=1.
- clr_cnt=1: match_cnt ← 0 and cnt_sat ← 0.
  - clr_cnt wins over a simultaneous increment.
  - clr_cnt does not affect state.
- Simultaneous load and clr_cnt: both take effect.
- state is zero-extended to 4 bits; the values N+1..15 are unreachable.
- Top-level mapping: uo_out[3:0] = state, uo_out[4] = z1, uo_out[5] = cnt_sat, uo_out[7:6] = match_cnt[1:0]; uio_oe = 0.

Test Plan:
- Reset value, then en=1, overlap=1, pattern 1011; drive x1 = 1,0,1,1,0,1,1 → state sequence 1,2,3,4,2,3,4. z1 is high in the cycle after the 4th and 7th bits; match_cnt = 2.
- Same stream with overlap=0 → states 1,2,3,4,0,1,1. A single z1 pulse after bit 4; match_cnt = 1.
- en toggling: stream 1,0,1 then en=0 for 3 cycles with x1 random, then 1 → state holds at 3 through the gaps, then reaches 4; z1 asserts once.
- load pat_in=1111 while state=3 → state=0 next cycle and match_cnt is unchanged. Then 20 consecutive ones with overlap=1 → 17 matches, so match_cnt saturates at 15 with cnt_sat=1. Then clr_cnt=1 together with a match → match_cnt=0, cnt_sat=0.
- rst asserted while state=3 and match_cnt=5 → next cycle state=0, z1=0, match_cnt=0, pattern restored to 1011 (verified by 1,0,1,1 → z1).
- Failure-function check, pattern 1001, overlap=1: x1 = 1,0,0,1,0,0,1 → states 1,2,3,4,2,3,4; x1 = 1,1 from state 1 → state stays 1.
